deck_dealer: RTL and testbench
==============================

Name: deck_dealer

Overview:
- Card source for the blackjack datapath. Replaces the fixed lookup-table draw modules with a shuffled deck served over a request/acknowledge handshake.
- Holds a 52-entry deck register array. Fills it with the identity permutation 0..51, then shuffles it in place (Fisher-Yates) using an on-chip LFSR.
- Deals one card per draw handshake until the deck is exhausted.
- The game FSM consumes the card code as rank = card % 13 and suit = card / 13.

Parameters:
- DECK_SIZE, 52, number of cards per deck; card codes are 0..DECK_SIZE-1.
- CARD_W, 6, card code width.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- shuffle_req  in  1  single-cycle pulse; rebuild and reshuffle the deck.
- draw_req  in  1  single-cycle pulse; request the next card.
- draw_ack  out  1  one-cycle pulse; card is valid in this cycle.
- card  out  CARD_W  dealt card code; holds its value until the next ack.
- cards_left  out  7  cards remaining in the deck.
- busy  out  1  high during FILL or SHUFFLE.
- empty  out  1  high in READY when cards_left == 0.

Behaviour:
- Reset values: draw_ack 0, card 0, cards_left 0, busy 1, empty 0.
- Reset values, internal: state FILL, fill index 0, lfsr = SEED, top = 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Advances every cycle from reset release, regardless of state.
- FILL:
  - deck[k] = k, one entry per cycle, k = 0..51 (52 cycles).
  - After the entry for k = 51 is written, go to SHUFFLE with i = 51.
- SHUFFLE:
  - Each cycle, cand = lfsr[5:0].
  - If cand <= i: swap deck[i] and deck[cand] in the same cycle (register array), then i decrements.
  - If cand > i: reject, hold i, retry next cycle.
  - cand == i is a legal no-op swap.
  - After the swap at i = 1, go to READY with top = 0 and cards_left = 52.
- READY:
  - draw_req with cards_left > 0: the next cycle drives draw_ack = 1 and card = deck[top]; top increments and cards_left decrements in that same cycle.
  - Latency from draw_req to ack is exactly 1 cycle.
  - draw_req in the ack cycle is accepted. Back-to-back draws every cycle are supported.
- Empty deck:
  - draw_req with cards_left == 0 is ignored: no ack, card holds its value, empty stays 1.
- shuffle_req:
  - In READY: go to FILL on the next cycle. busy rises and cards_left = 0.
  - An outstanding ack for a draw accepted in the previous cycle still completes.
  - shuffle_req in FILL or SHUFFLE is ignored.
  - draw_req in FILL or SHUFFLE is ignored; it is not queued.
- Simultaneous shuffle_req and draw_req in READY: shuffle wins, the draw is dropped, no ack.
- Reset asserted mid-FILL, mid-SHUFFLE or mid-draw:
  - Immediate return to reset values.
  - The deck contents are don't-care, because FILL rewrites every entry.
- Width rules: cards_left saturates at 0 and never wraps. top never exceeds 52.
- busy = (state != READY).

Decomposition:
- Shared package dealer_pkg holds:
  - DECK_SIZE, CARD_W.
  - State encoding: FILL = 2'd0, SHUFFLE = 2'd1, READY = 2'd2.
  - LFSR_MASK = 16'hB400.
- One sub-module, lfsr16: ports CLOCK_50, resetn, seed, q[15:0]; free-running.
- FSM, deck array and handshake live in deck_dealer.

Test Plan:
- Reset release -> busy = 1 for at least 52 + 51 cycles; then busy = 0, cards_left = 52, empty = 0, draw_ack = 0.
- 52 draws, one every 2 cycles:
  - Each draw_ack arrives exactly 1 cycle after its req.
  - The collected cards form a permutation of 0..51 (no duplicates).
  - cards_left steps 51..0 and empty = 1 after the last ack.
- 53rd draw_req -> no draw_ack within 5 cycles; card keeps the 52nd value; cards_left = 0.
- Two runs from reset with SEED = 16'hACE1 -> identical 52-card sequences.
- A run with SEED = 16'h0001 -> a different sequence that is still a permutation.
- shuffle_req and draw_req in the same READY cycle -> no ack, busy = 1 on the next cycle.
- draw_req during busy -> no ack.
- resetn pulsed low mid-SHUFFLE, then released -> the post-reset sequence equals the run-1 sequence.

Source files
------------

// File: rtl/dealer_pkg.sv
// Shared definitions for the card dealer: deck geometry, FSM state
// encoding and the LFSR feedback mask / step function.
package dealer_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          CARD_W    = 6;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        SHUFFLE = 2'd1,
        READY   = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR.
// Ports:
//   CLOCK_50 - clock
//   resetn   - async active-low reset, loads seed
//   seed     - reset value, must be nonzero
//   q        - current LFSR state
module lfsr16
    import dealer_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) q <= seed;
        else         q <= lfsr_next(q);
    end

endmodule

// File: rtl/deck_dealer.sv
// Shuffled-deck card source. Fills a register-array deck with 0..DECK_SIZE-1,
// Fisher-Yates shuffles it with an LFSR, then deals one card per draw_req.
// Ports:
//   CLOCK_50, resetn         - clock, async active-low reset
//   shuffle_req              - pulse: rebuild and reshuffle (READY only)
//   draw_req                 - pulse: deal next card (READY only)
//   draw_ack                 - one-cycle pulse, card valid this cycle
//   card                     - last dealt card, held until the next ack
//   cards_left               - cards remaining
//   busy                     - high while filling or shuffling
//   empty                    - high in READY with no cards left
module deck_dealer #(
    parameter int          DECK_SIZE = 52,
    parameter int          CARD_W    = 6,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              shuffle_req,
    input  logic              draw_req,
    output logic              draw_ack,
    output logic [CARD_W-1:0] card,
    output logic [6:0]        cards_left,
    output logic              busy,
    output logic              empty
);
    import dealer_pkg::*;

    logic [CARD_W-1:0] deck [DECK_SIZE];
    state_t            state;
    logic [CARD_W-1:0] fill_idx;
    logic [CARD_W-1:0] shuf_i;
    logic [CARD_W-1:0] top;
    logic [15:0]       lfsr_q;
    logic [CARD_W-1:0] cand;
    logic              fill_en;
    logic              swap_en;
    logic              draw_ok;

    lfsr16 u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .seed     (SEED),
        .q        (lfsr_q)
    );

    // Candidates above the current index are rejected and retried on the
    // next LFSR value, which keeps the permutation unbiased.
    assign cand    = lfsr_q[CARD_W-1:0];
    assign fill_en = (state == FILL);
    assign swap_en = (state == SHUFFLE) && (cand <= shuf_i);
    // Shuffle has priority over a simultaneous draw.
    assign draw_ok = (state == READY) && draw_req && !shuffle_req && (cards_left != 7'd0);

    assign busy  = (state != READY);
    assign empty = (state == READY) && (cards_left == 7'd0);

    // Deck storage has no reset: FILL rewrites every entry before use.
    // cand == shuf_i gives both assignments the same value (a no-op swap).
    always_ff @(posedge CLOCK_50) begin
        if (fill_en) begin
            deck[fill_idx] <= fill_idx;
        end else if (swap_en) begin
            deck[shuf_i] <= deck[cand];
            deck[cand]   <= deck[shuf_i];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= FILL;
            fill_idx   <= '0;
            shuf_i     <= '0;
            top        <= '0;
            cards_left <= '0;
            draw_ack   <= 1'b0;
            card       <= '0;
        end else begin
            draw_ack <= 1'b0;
            case (state)
                FILL: begin
                    if (fill_idx == CARD_W'(DECK_SIZE - 1)) begin
                        state    <= SHUFFLE;
                        fill_idx <= '0;
                        shuf_i   <= CARD_W'(DECK_SIZE - 1);
                    end else begin
                        fill_idx <= fill_idx + 1'b1;
                    end
                end
                SHUFFLE: begin
                    if (swap_en) begin
                        // Position 0 needs no swap; the deck is final after i = 1.
                        if (shuf_i == CARD_W'(1)) begin
                            state      <= READY;
                            top        <= '0;
                            cards_left <= 7'(DECK_SIZE);
                        end else begin
                            shuf_i <= shuf_i - 1'b1;
                        end
                    end
                end
                READY: begin
                    if (shuffle_req) begin
                        state      <= FILL;
                        fill_idx   <= '0;
                        cards_left <= '0;
                    end else if (draw_ok) begin
                        draw_ack   <= 1'b1;
                        card       <= deck[top];
                        top        <= top + 1'b1;
                        cards_left <= cards_left - 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_deck_dealer.sv
module tb_deck_dealer;
    logic       clk = 1'b0;
    logic       resetn;
    logic       shuffle_a, draw_a, shuffle_b, draw_b;
    logic       ack_a, ack_b, busy_a, busy_b, empty_a, empty_b;
    logic [5:0] card_a, card_b;
    logic [6:0] left_a, left_b;

    int errs = 0;
    int checks = 0;

    logic [5:0] cur  [52];
    logic [5:0] run1 [52];
    logic [5:0] runb [52];

    typedef struct {
        logic  dr;
        logic  sh;
        logic  ack;
        int    left;
        logic  busy;
        logic  empty;
        int    idx;
        string name;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    deck_dealer #(.SEED(16'hACE1)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .shuffle_req(shuffle_a), .draw_req(draw_a),
        .draw_ack(ack_a), .card(card_a), .cards_left(left_a), .busy(busy_a), .empty(empty_a)
    );

    deck_dealer #(.SEED(16'h0001)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .shuffle_req(shuffle_b), .draw_req(draw_b),
        .draw_ack(ack_b), .card(card_b), .cards_left(left_b), .busy(busy_b), .empty(empty_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_ready(input bit s, output int n);
        n = 0;
        while ((s ? busy_b : busy_a) && n < 5000) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(s ? busy_b : busy_a), 0);
    endtask

    // Deal the whole deck, one request every 2 cycles, into cur[].
    task automatic draw_deck(input bit s);
        logic [51:0] seen;
        logic [5:0]  c;
        seen = '0;
        for (int k = 0; k < 52; k++) begin
            if (s) draw_b = 1'b1; else draw_a = 1'b1;
            tick();
            draw_a = 1'b0;
            draw_b = 1'b0;
            chk("ack_latency", 32'(s ? ack_b : ack_a), 1);
            chk("cards_left_step", 32'(s ? left_b : left_a), 32'(51 - k));
            c = s ? card_b : card_a;
            cur[k] = c;
            chk("perm_unique", 32'((c < 6'd52) && !seen[c]), 1);
            if (c < 6'd52) seen[c] = 1'b1;
            tick();
            chk("ack_one_cycle", 32'(s ? ack_b : ack_a), 0);
        end
        chk("empty_after_last", 32'(s ? empty_b : empty_a), 1);
        chk("left_after_last", 32'(s ? left_b : left_a), 0);
    endtask

    initial begin
        int n;
        int same;
        logic [5:0] last;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 51, 1'b0, 1'b0, 0, "draw1"};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 50, 1'b0, 1'b0, 1, "draw_b2b"};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 50, 1'b0, 1'b0, 1, "idle_hold"};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 49, 1'b0, 1'b0, 2, "draw3"};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 0,  1'b1, 1'b0, 2, "shuffle_beats_draw"};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 0,  1'b1, 1'b0, 2, "draw_while_busy"};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 0,  1'b1, 1'b0, 2, "shuffle_while_busy"};

        resetn = 1'b0;
        shuffle_a = 1'b0; draw_a = 1'b0;
        shuffle_b = 1'b0; draw_b = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(ack_a), 0);
        chk("rst_card", 32'(card_a), 0);
        chk("rst_left", 32'(left_a), 0);
        chk("rst_busy", 32'(busy_a), 1);
        chk("rst_empty", 32'(empty_a), 0);
        resetn = 1'b1;

        // Run 1: fill + shuffle take at least 52 + 51 cycles.
        wait_ready(1'b0, n);
        chk("busy_min_cycles", 32'(n >= 103), 1);
        chk("ready_left", 32'(left_a), 52);
        chk("ready_empty", 32'(empty_a), 0);
        chk("ready_ack", 32'(ack_a), 0);
        draw_deck(1'b0);
        run1 = cur;

        // Request on an exhausted deck is ignored.
        last = card_a;
        draw_a = 1'b1;
        tick();
        draw_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("no_ack_empty", 32'(ack_a), 0);
            tick();
        end
        chk("card_hold_empty", 32'(card_a), 32'(last));
        chk("left_sat_zero", 32'(left_a), 0);
        chk("empty_stays", 32'(empty_a), 1);

        // Other seed: still a permutation, different order.
        wait_ready(1'b1, n);
        draw_deck(1'b1);
        runb = cur;
        same = 1;
        for (int k = 0; k < 52; k++) if (runb[k] != run1[k]) same = 0;
        chk("seed_differs", 32'(same), 0);

        // Run 2 from reset: identical sequence.
        do_reset();
        wait_ready(1'b0, n);
        draw_deck(1'b0);
        for (int k = 0; k < 52; k++) chk("repeat_seq", 32'(cur[k]), 32'(run1[k]));

        // Handshake corner cases from a fresh deck.
        do_reset();
        wait_ready(1'b0, n);
        for (int v = 0; v < 7; v++) begin
            draw_a    = vecs[v].dr;
            shuffle_a = vecs[v].sh;
            tick();
            draw_a    = 1'b0;
            shuffle_a = 1'b0;
            chk({vecs[v].name, "_ack"},   32'(ack_a),   32'(vecs[v].ack));
            chk({vecs[v].name, "_left"},  32'(left_a),  32'(vecs[v].left));
            chk({vecs[v].name, "_busy"},  32'(busy_a),  32'(vecs[v].busy));
            chk({vecs[v].name, "_empty"}, 32'(empty_a), 32'(vecs[v].empty));
            chk({vecs[v].name, "_card"},  32'(card_a),  32'(run1[vecs[v].idx]));
        end

        // Reset in the middle of the reshuffle replays run 1.
        for (int k = 0; k < 60; k++) tick();
        chk("mid_shuffle_busy", 32'(busy_a), 1);
        do_reset();
        chk("post_reset_left", 32'(left_a), 0);
        wait_ready(1'b0, n);
        draw_deck(1'b0);
        for (int k = 0; k < 52; k++) chk("reset_mid_shuffle_seq", 32'(cur[k]), 32'(run1[k]));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
